// File: rtl/muldiv_hilo_ctrl.sv
// muldiv_hilo_ctrl: multi-cycle MULT/MULTU/DIV/DIVU/MTHI/MTLO sequencer driving the HI/LO write port
module muldiv_hilo_ctrl #(
    parameter int DIV_ITERS = 32
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start_i,
    input  logic [2:0]  op_i,
    input  logic [31:0] src_a_i,
    input  logic [31:0] src_b_i,
    input  logic [31:0] hi_cur_i,
    input  logic [31:0] lo_cur_i,
    input  logic        cancel_i,
    output logic        stall_o,
    output logic        busy_o,
    output logic        hilo_wen_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);
    localparam int CW = $clog2(DIV_ITERS);
    localparam logic [CW-1:0] LAST = CW'(DIV_ITERS - 1);
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
    state_t state;
    logic mul_u, neg_q, neg_r, valid_op, div_s, ge;
    logic [31:0] a, b, rem, abs_a, abs_b, nrem, nquo;
    logic [CW-1:0] cnt;
    logic [32:0] sh, diff;
    logic [63:0] prod;
    assign valid_op = op_i < 3'd6;
    assign div_s = op_i == 3'd2;
    assign abs_a = div_s && src_a_i[31] ? -src_a_i : src_a_i;
    assign abs_b = div_s && src_b_i[31] ? -src_b_i : src_b_i;
    assign prod = mul_u ? {32'b0, a} * {32'b0, b} : {{32{a[31]}}, a} * {{32{b[31]}}, b};
    // In DIV, a holds the quotient being built while dividend bits shift out of its top
    assign sh = {rem, a[31]};
    assign diff = sh - {1'b0, b};
    assign ge = !diff[32];
    assign nrem = ge ? diff[31:0] : sh[31:0];
    assign nquo = {a[30:0], ge};
    assign stall_o = state == IDLE ? start_i & valid_op & !cancel_i : (state == MUL || state == DIV) & !cancel_i;
    assign busy_o = state != IDLE;
    assign hilo_wen_o = state == DONE & !cancel_i;
    // Sequence the operation and register the HI/LO result on entry to DONE
    always_ff @(posedge clk) begin
        if (resetn) begin
            state <= IDLE;
            mul_u <= 1'b0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            a <= '0;
            b <= '0;
            rem <= '0;
            cnt <= '0;
            hi_o <= '0;
            lo_o <= '0;
        end else if (cancel_i) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: if (start_i && valid_op) begin
                    mul_u <= op_i[0];
                    neg_q <= div_s & (src_a_i[31] ^ src_b_i[31]);
                    neg_r <= div_s & src_a_i[31];
                    a <= abs_a;
                    b <= abs_b;
                    rem <= '0;
                    cnt <= '0;
                    if (op_i == 3'd4) begin
                        hi_o <= src_a_i;
                        lo_o <= lo_cur_i;
                        state <= DONE;
                    end else if (op_i == 3'd5) begin
                        hi_o <= hi_cur_i;
                        lo_o <= src_a_i;
                        state <= DONE;
                    end else begin
                        state <= op_i[1] ? DIV : MUL;
                    end
                end
                MUL: begin
                    hi_o <= prod[63:32];
                    lo_o <= prod[31:0];
                    state <= DONE;
                end
                DIV: begin
                    rem <= nrem;
                    a <= nquo;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        hi_o <= neg_r ? -nrem : nrem;
                        lo_o <= neg_q ? -nquo : nquo;
                        state <= DONE;
                    end
                end
                DONE: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// tb_muldiv_hilo_ctrl: scoreboard bench for the HI/LO multiply/divide controller
module tb_muldiv_hilo_ctrl;
    logic clk = 0, resetn = 1, start_i = 0, cancel_i = 0;
    logic [2:0] op_i = 0;
    logic [31:0] src_a_i = 0, src_b_i = 0, hi_cur_i = 0, lo_cur_i = 0;
    logic stall_o, busy_o, hilo_wen_o;
    logic [31:0] hi_o, lo_o;
    typedef struct {logic [31:0] hi; logic [31:0] lo; int cyc;} exp_t;
    exp_t sb[$];
    int checks = 0, passed = 0, commits = 0, cyc = 0, wen_count = 0;

    muldiv_hilo_ctrl dut (
        .clk(clk), .resetn(resetn), .start_i(start_i), .op_i(op_i),
        .src_a_i(src_a_i), .src_b_i(src_b_i), .hi_cur_i(hi_cur_i), .lo_cur_i(lo_cur_i),
        .cancel_i(cancel_i), .stall_o(stall_o), .busy_o(busy_o), .hilo_wen_o(hilo_wen_o),
        .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk = ~clk;
    // Cycle index: after posedge n the bench is in cycle n
    always @(posedge clk) cyc <= cyc + 1;
    // Count every write strobe to catch spurious commits
    always @(negedge clk) if (hilo_wen_o) wen_count <= wen_count + 1;

    // Present a request for one cycle starting now (just after a posedge); returns stall seen that cycle
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, output logic st);
        start_i = 1; op_i = op; src_a_i = a; src_b_i = b;
        @(negedge clk);
        st = stall_o;
        @(posedge clk); #1;
        start_i = 0;
    endtask

    task automatic expect_commit(input logic [31:0] hi, input logic [31:0] lo, input int lat);
        sb.push_back('{hi, lo, cyc + lat});
        commits++;
    endtask

    // Wait for a write strobe; reports its cycle and whether stall was held before and dropped at commit
    task automatic await_wen(input int budget, output bit seen, output int wcyc, output bit held, output logic st_done);
        seen = 0; wcyc = -1; held = 1; st_done = 1'bx;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (hilo_wen_o) begin
                seen = 1; wcyc = cyc; st_done = stall_o;
            end else held &= stall_o;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1 resetn = 0;
        @(negedge clk);
        checks++; if ({busy_o, stall_o, hilo_wen_o} !== 3'b000) $display("FAIL reset_ctl got %b want 000", {busy_o, stall_o, hilo_wen_o}); else passed++;
        checks++; if ({hi_o, lo_o} !== 64'h0) $display("FAIL reset_hilo got %h want 0", {hi_o, lo_o}); else passed++;
    endtask

    task automatic test_mult();
        logic st, sd; bit seen, held; int wc; exp_t e;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            expect_commit(k == 0 ? 32'hFFFFFFFF : 32'h4, 32'hFFFFFFF1, 2);
            issue(k == 0 ? 3'd0 : 3'd1, 32'hFFFFFFFD, 32'd5, st);
            await_wen(10, seen, wc, held, sd);
            e = sb.pop_front();
            checks++; if (st !== 1'b1) $display("FAIL mult%0d stall_start got %b want 1", k, st); else passed++;
            checks++; if (!seen || wc != e.cyc) $display("FAIL mult%0d wen_cycle got %0d want %0d", k, wc, e.cyc); else passed++;
            checks++; if ({hi_o, lo_o} !== {e.hi, e.lo}) $display("FAIL mult%0d hilo got %h want %h", k, {hi_o, lo_o}, {e.hi, e.lo}); else passed++;
            checks++; if (!held || sd !== 1'b0) $display("FAIL mult%0d stall_shape got held=%0d done=%b want held=1 done=0", k, held, sd); else passed++;
        end
    endtask

    task automatic test_div();
        logic [2:0] top[6];
        logic [31:0] ta[6], tb[6], thi[6], tlo[6];
        logic st, sd; bit seen, held; int wc; exp_t e;
        top = '{3'd3, 3'd2, 3'd2, 3'd3, 3'd2, 3'd3};
        ta  = '{32'd100, 32'hFFFFFFF9, 32'd7, 32'h12345678, 32'hFFFFFFF8, 32'hFFFFFFFF};
        tb  = '{32'd7, 32'd2, 32'hFFFFFFFE, 32'd0, 32'd0, 32'd16};
        thi = '{32'd2, 32'hFFFFFFFF, 32'd1, 32'h12345678, 32'hFFFFFFF8, 32'hF};
        tlo = '{32'd14, 32'hFFFFFFFD, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'd1, 32'h0FFFFFFF};
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            expect_commit(thi[k], tlo[k], 33);
            issue(top[k], ta[k], tb[k], st);
            await_wen(50, seen, wc, held, sd);
            e = sb.pop_front();
            checks++; if (!seen || wc != e.cyc) $display("FAIL div%0d wen_cycle got %0d want %0d", k, wc, e.cyc); else passed++;
            checks++; if ({hi_o, lo_o} !== {e.hi, e.lo}) $display("FAIL div%0d hilo got %h want %h", k, {hi_o, lo_o}, {e.hi, e.lo}); else passed++;
            checks++; if (st !== 1'b1 || !held || sd !== 1'b0) $display("FAIL div%0d stall_shape got start=%b held=%0d done=%b want 1/1/0", k, st, held, sd); else passed++;
        end
    endtask

    task automatic test_mtx();
        logic st, sd; bit seen, held; int wc; exp_t e;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            hi_cur_i = k == 0 ? 32'h55 : 32'h22;
            lo_cur_i = k == 0 ? 32'h11 : 32'h66;
            expect_commit(k == 0 ? 32'hDEADBEEF : 32'h22, k == 0 ? 32'h11 : 32'hCAFEF00D, 1);
            issue(k == 0 ? 3'd4 : 3'd5, k == 0 ? 32'hDEADBEEF : 32'hCAFEF00D, 32'h0, st);
            await_wen(5, seen, wc, held, sd);
            e = sb.pop_front();
            checks++; if (!seen || wc != e.cyc) $display("FAIL mt%0d wen_cycle got %0d want %0d", k, wc, e.cyc); else passed++;
            checks++; if ({hi_o, lo_o} !== {e.hi, e.lo}) $display("FAIL mt%0d hilo got %h want %h", k, {hi_o, lo_o}, {e.hi, e.lo}); else passed++;
            checks++; if (st !== 1'b1 || sd !== 1'b0) $display("FAIL mt%0d stall got start=%b done=%b want 1/0", k, st, sd); else passed++;
        end
    endtask

    task automatic test_invalid_op();
        logic st; bit any_busy;
        for (int k = 6; k < 8; k++) begin
            @(posedge clk); #1;
            issue(3'(k), 32'h1, 32'h1, st);
            any_busy = 0;
            repeat (3) begin
                @(negedge clk);
                any_busy |= busy_o | hilo_wen_o;
            end
            checks++; if (st !== 1'b0 || any_busy) $display("FAIL op%0d_ignored got stall=%b busy_or_wen=%0d want 0/0", k, st, any_busy); else passed++;
        end
    endtask

    task automatic test_cancel();
        logic st, sd; bit seen, held; int wc; exp_t e;
        @(posedge clk); #1;
        issue(3'd2, 32'd1000, 32'd3, st);
        repeat (9) @(posedge clk);
        #1 cancel_i = 1;
        @(negedge clk);
        checks++; if ({stall_o, hilo_wen_o} !== 2'b00) $display("FAIL cancel_div got stall/wen %b want 00", {stall_o, hilo_wen_o}); else passed++;
        @(posedge clk); #1 cancel_i = 0;
        expect_commit(32'h0, 32'd42, 2);
        issue(3'd0, 32'd6, 32'd7, st);
        await_wen(50, seen, wc, held, sd);
        e = sb.pop_front();
        checks++; if (!seen || wc != e.cyc || st !== 1'b1) $display("FAIL cancel_then_mult wen_cycle got %0d want %0d", wc, e.cyc); else passed++;
        checks++; if ({hi_o, lo_o} !== {e.hi, e.lo}) $display("FAIL cancel_then_mult hilo got %h want %h", {hi_o, lo_o}, {e.hi, e.lo}); else passed++;
    endtask

    task automatic test_busy_ignore();
        logic st, sd; bit seen, held; int wc; exp_t e;
        @(posedge clk); #1;
        expect_commit(32'd2, 32'd14, 33);
        issue(3'd3, 32'd100, 32'd7, st);
        repeat (2) @(posedge clk);
        #1 start_i = 1; op_i = 3'd0; src_a_i = 32'h9; src_b_i = 32'h9;
        repeat (2) @(posedge clk);
        #1 start_i = 0;
        await_wen(50, seen, wc, held, sd);
        e = sb.pop_front();
        checks++; if (!seen || wc != e.cyc) $display("FAIL busy_ignore wen_cycle got %0d want %0d", wc, e.cyc); else passed++;
        checks++; if ({hi_o, lo_o} !== {e.hi, e.lo}) $display("FAIL busy_ignore hilo got %h want %h", {hi_o, lo_o}, {e.hi, e.lo}); else passed++;
    endtask

    task automatic test_cancel_done();
        logic st;
        @(posedge clk); #1;
        issue(3'd4, 32'h77, 32'h0, st);
        cancel_i = 1;
        @(negedge clk);
        checks++; if ({stall_o, hilo_wen_o} !== 2'b00) $display("FAIL cancel_done got stall/wen %b want 00", {stall_o, hilo_wen_o}); else passed++;
        @(posedge clk); #1 cancel_i = 0;
        @(negedge clk);
        checks++; if (busy_o !== 1'b0) $display("FAIL cancel_done_idle got busy %b want 0", busy_o); else passed++;
    endtask

    task automatic test_reset_mid_div();
        logic st;
        @(posedge clk); #1;
        issue(3'd3, 32'd100, 32'd7, st);
        repeat (5) @(posedge clk);
        #1 resetn = 1;
        repeat (2) @(posedge clk);
        #1 resetn = 0;
        @(negedge clk);
        checks++; if ({busy_o, stall_o, hilo_wen_o} !== 3'b000) $display("FAIL reset_mid ctl got %b want 000", {busy_o, stall_o, hilo_wen_o}); else passed++;
        checks++; if ({hi_o, lo_o} !== 64'h0) $display("FAIL reset_mid hilo got %h want 0", {hi_o, lo_o}); else passed++;
        repeat (40) @(posedge clk);
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_mtx();
        test_invalid_op();
        test_cancel();
        test_busy_ignore();
        test_cancel_done();
        test_reset_mid_div();
        @(negedge clk);
        checks++; if (wen_count != commits) $display("FAIL wen_total got %0d want %0d", wen_count, commits); else passed++;
        checks++; if (sb.size() != 0) $display("FAIL scoreboard_left got %0d want 0", sb.size()); else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
